uart_baud_ctrl: RTL and testbench

// Safe run-time baud-rate reconfiguration controller for the FPGA UART. Owns the

---
 rtl/uart_baud_ctrl.sv | 110 +++++++++++
 tb/tb_uart_baud_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_baud_ctrl.sv
// Run-time baud select controller: pause Tx/Rx, drain frames,
// switch the select, settle for a number of baud ticks, then release.
module uart_baud_ctrl #(
  parameter logic [1:0]  DEFAULT_BAUD_SEL = 2'b00,
  parameter int unsigned SETTLE_TICKS     = 16,
  parameter int unsigned TIMEOUT_CYCLES   = 1048576
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req_valid_i,
  input  logic [1:0] req_sel_i,
  output logic       req_ready_o,
  input  logic       tx_busy_i,
  input  logic       rx_busy_i,
  input  logic       baud_en_i,
  output logic [1:0] baud_sel_o,
  output logic       pause_o,
  output logic       done_o,
  output logic       timeout_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int KW = $clog2(SETTLE_TICKS + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [KW-1:0] KMAX = KW'(SETTLE_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE, DRAIN, SWITCH, SETTLE
  } state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic [1:0]    r_sel;
  logic [1:0]    r_pend;
  logic [TW-1:0] r_timer;
  logic [KW-1:0] r_tick;
  logic          r_done;
  logic          r_timeout;
  logic          w_done_nx;
  logic          w_to_nx;
  logic          w_accept;
  logic          w_idle;

  assign w_idle = !tx_busy_i && !rx_busy_i;

  always_comb begin
    w_state_nx = r_state;
    w_done_nx  = 1'b0;
    w_to_nx    = 1'b0;
    w_accept   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (req_valid_i) begin
          if (req_sel_i == r_sel) begin
            w_done_nx = 1'b1;
          end else begin
            w_accept   = 1'b1;
            w_state_nx = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Drained frames win over a timeout on the same edge
        if (w_idle) begin
          w_state_nx = SWITCH;
        end else if (r_timer == TMAX) begin
          w_state_nx = IDLE;
          w_to_nx    = 1'b1;
        end
      end
      SWITCH: w_state_nx = SETTLE;
      SETTLE: begin
        if (baud_en_i && r_tick == KMAX) begin
          w_state_nx = IDLE;
          w_done_nx  = 1'b1;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_sel     <= DEFAULT_BAUD_SEL;
      r_pend    <= DEFAULT_BAUD_SEL;
      r_timer   <= '0;
      r_tick    <= '0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_done    <= w_done_nx;
      r_timeout <= w_to_nx;
      if (w_accept) r_pend <= req_sel_i;
      if (r_state == SWITCH) r_sel <= r_pend;
      if (r_state != DRAIN) r_timer <= '0;
      else if (r_timer != TMAX) r_timer <= r_timer + TW'(1);
      if (r_state != SETTLE) r_tick <= '0;
      else if (baud_en_i && r_tick != KMAX) r_tick <= r_tick + KW'(1);
    end
  end

  assign req_ready_o = (r_state == IDLE);
  assign pause_o     = (r_state != IDLE);
  assign baud_sel_o  = r_sel;
  assign done_o      = r_done;
  assign timeout_o   = r_timeout;

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Directed bench for uart_baud_ctrl with a completion scoreboard.
// Expected completions are queued at request time, popped on done/timeout.
module tb_uart_baud_ctrl;

  typedef struct {
    logic       is_to;
    logic [1:0] sel;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_sel = 2'b00;
  logic       req_ready;
  logic       tx_busy = 1'b0;
  logic       rx_busy = 1'b0;
  logic       baud_en = 1'b0;
  logic [1:0] baud_sel;
  logic       pause;
  logic       done;
  logic       timeout;

  int   ncmp = 0;
  int   nerr = 0;
  exp_t q[$];

  uart_baud_ctrl #(
    .DEFAULT_BAUD_SEL(2'b00),
    .SETTLE_TICKS(4),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .req_valid_i(req_valid),
    .req_sel_i(req_sel),
    .req_ready_o(req_ready),
    .tx_busy_i(tx_busy),
    .rx_busy_i(rx_busy),
    .baud_en_i(baud_en),
    .baud_sel_o(baud_sel),
    .pause_o(pause),
    .done_o(done),
    .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    baud_en = 1'b0;
    step();
    baud_en = 1'b1;
    step();
    baud_en = 1'b0;
  endtask

  task automatic request(input logic [1:0] s, input logic is_to,
                         input logic [1:0] final_sel);
    req_valid = 1'b1;
    req_sel   = s;
    chk("req_ready", 32'(req_ready), 32'd1);
    q.push_back('{is_to, final_sel});
    step();
    req_valid = 1'b0;
  endtask

  // Scoreboard: every done/timeout pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && (done || timeout)) begin
      chk("done_and_timeout", 32'(done && timeout), 32'd0);
      if (q.size() == 0) begin
        chk("unexpected_completion", 32'(q.size()), 32'd1);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_kind_timeout", 32'(timeout), 32'(e.is_to));
        chk("sb_baud_sel", 32'(baud_sel), 32'(e.sel));
      end
    end
  end

  initial begin
    // Reset state
    #1;
    chk("rst_sel", 32'(baud_sel), 32'd0);
    chk("rst_pause", 32'(pause), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Idle path 00 -> 10
    request(2'b10, 1'b0, 2'b10);
    chk("idle_pause", 32'(pause), 32'd1);
    chk("idle_ready", 32'(req_ready), 32'd0);
    chk("idle_sel_n1", 32'(baud_sel), 32'd0);
    step();
    chk("idle_sel_n2", 32'(baud_sel), 32'd0);
    step();
    chk("idle_sel_sw", 32'(baud_sel), 32'd2);
    for (int i = 0; i < 3; i++) begin
      pulse();
      chk("idle_settle_pause", 32'(pause), 32'd1);
    end
    pulse();
    chk("idle_end_pause", 32'(pause), 32'd0);
    chk("idle_end_done", 32'(done), 32'd1);
    step();
    chk("idle_done_1cyc", 32'(done), 32'd0);

    // Drain 10 -> 01 with tx busy for 50 cycles
    tx_busy = 1'b1;
    request(2'b01, 1'b0, 2'b01);
    for (int i = 0; i < 50; i++) begin
      step();
      chk("drain_hold_sel", 32'(baud_sel), 32'd2);
    end
    chk("drain_pause", 32'(pause), 32'd1);
    chk("drain_no_to", 32'(timeout), 32'd0);
    tx_busy = 1'b0;
    step();
    chk("drain_sel_sw0", 32'(baud_sel), 32'd2);
    step();
    chk("drain_sel_sw1", 32'(baud_sel), 32'd1);
    repeat (4) pulse();
    chk("drain_end_pause", 32'(pause), 32'd0);
    step();

    // Timeout with rx stuck busy
    rx_busy = 1'b1;
    request(2'b11, 1'b1, 2'b01);
    repeat (63) step();
    chk("to_not_yet", 32'(timeout), 32'd0);
    chk("to_pause_before", 32'(pause), 32'd1);
    step();
    chk("to_pulse", 32'(timeout), 32'd1);
    chk("to_pause", 32'(pause), 32'd0);
    chk("to_sel", 32'(baud_sel), 32'd1);
    chk("to_ready", 32'(req_ready), 32'd1);
    rx_busy = 1'b0;

    // No-op request right after timeout
    request(2'b01, 1'b0, 2'b01);
    chk("noop_done", 32'(done), 32'd1);
    chk("noop_pause", 32'(pause), 32'd0);
    chk("noop_timeout", 32'(timeout), 32'd0);
    step();
    chk("noop_done_1cyc", 32'(done), 32'd0);
    chk("noop_pause2", 32'(pause), 32'd0);

    // Back-to-back; baud_en in DRAIN/SWITCH must not count
    request(2'b11, 1'b0, 2'b11);
    baud_en = 1'b1;
    step();
    step();
    baud_en = 1'b0;
    chk("b2b_sel", 32'(baud_sel), 32'd3);
    req_valid = 1'b1;
    req_sel   = 2'b00;
    q.push_back('{1'b0, 2'b00});
    chk("b2b_busy_ready", 32'(req_ready), 32'd0);
    repeat (3) pulse();
    chk("b2b_pause_3", 32'(pause), 32'd1);
    pulse();
    chk("b2b_release", 32'(pause), 32'd0);
    chk("b2b_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    chk("b2b_second_acc", 32'(pause), 32'd1);
    step();
    step();
    chk("b2b_sel2", 32'(baud_sel), 32'd0);
    repeat (4) pulse();
    chk("b2b_end_pause", 32'(pause), 32'd0);
    step();

    // Async reset mid-SETTLE abandons the request
    request(2'b10, 1'b0, 2'b10);
    step();
    step();
    pulse();
    pulse();
    chk("rst2_pre_sel", 32'(baud_sel), 32'd2);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("rst2_sel", 32'(baud_sel), 32'd0);
    chk("rst2_pause", 32'(pause), 32'd0);
    chk("rst2_ready", 32'(req_ready), 32'd1);
    step();
    rst_n = 1'b1;
    repeat (6) pulse();
    chk("rst2_idle", 32'(pause), 32'd0);
    chk("sb_empty", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
